cbus_arbiter: RTL

Arbitrates NUM_REQ cache-bus masters (icache, dcache, uncached path) onto the single cache-bus port of the AXI bridge. It grants exactly one requester per transaction. While the transaction runs it forwards that requester's cbus_req_t downstream and steers the bridge's cbus_resp_t back to it. Ownership is held until the beat flagged `last`. It sits between the cache subsystem and the cache-bus-to-AXI bridge in the core's memory path.

---
 rtl/cbus_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: grants one cache-bus requester per transaction, holding ownership until `last`.
// Define CBUS_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (index 0 highest).
package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [31:0] data;
        logic [3:0]  strb;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic             aclk,
    input  logic             areset,
    input  cbus_req_t        ireqs  [NUM_REQ],
    output cbus_resp_t       oresps [NUM_REQ],
    output cbus_req_t        oreq,
    input  cbus_resp_t       iresp,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy
);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] win_idx;
    logic             win_valid;

`ifdef CBUS_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr_q;

    // Search upward from rr_ptr with wrap; first valid requester wins.
    always_comb begin
        int unsigned j;
        j         = 0;
        win_valid = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = 32'(rr_ptr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!win_valid && ireqs[IDX_W'(j)].valid) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end
`else
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!win_valid && ireqs[i].valid) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= StIdle;
            grant_q  <= '0;
`ifdef CBUS_ARB_RR_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (win_valid) begin
                        state_q <= StBusy;
                        grant_q <= win_idx;
`ifdef CBUS_ARB_RR_EN
                        rr_ptr_q <= (32'(win_idx) + 1 == NUM_REQ) ? '0 : IDX_W'(win_idx + 1'b1);
`endif
                    end
                end
                StBusy: begin
                    if (iresp.ready && iresp.last) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = (state_q == StBusy);
    assign grant_idx = grant_q;

    // Request and response paths are combinational so data/strobe follow the owner beat by beat.
    always_comb begin
        oreq = '0;
        if (busy) oreq = ireqs[grant_q];
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            oresps[i] = '0;
            if (busy && grant_q == IDX_W'(i)) oresps[i] = iresp;
        end
    end

endmodule
